maj_vote_pipe: RTL and testbench

Parametrised, pipelined N-input vote/reduce unit with a valid/ready handshake. It generalises the 7-input, single-output reduction cone used in the gate-level benchmarks. Width and reduction mode are configurable, a registered popcount and tie flag are exported, and the unit carries a beat counter. It sits between a stimulus source and a result sink.

---
 rtl/maj_vote_pkg.sv | 18 +
 rtl/maj_vote_pipe_popcnt_tree.sv | 38 +++
 rtl/maj_vote_pipe.sv | 115 +++++++++++
 tb/tb_maj_vote_pipe.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maj_vote_pkg.sv
// Shared types and helpers for the pipelined vote/reduce unit.
package maj_vote_pkg;

    typedef enum logic [1:0] {
        MODE_MAJ = 2'd0,
        MODE_XOR = 2'd1,
        MODE_AND = 2'd2,
        MODE_OR  = 2'd3
    } mode_e;

    localparam int PIPE_LAT = 2;

    // Width needed to hold a population count of n bits (0..n inclusive).
    function automatic int pop_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/maj_vote_pipe_popcnt_tree.sv
// Combinational popcount built as a balanced binary adder tree.
// The input is padded with zeros up to the next power of two.
module popcnt_tree
    import maj_vote_pkg::*;
#(
    parameter int N = 7
) (
    input  logic [N-1:0]          data,
    output logic [pop_w(N)-1:0]   pop
);

    localparam int PW     = pop_w(N);
    localparam int LEVELS = $clog2(N);
    localparam int LEAVES = 1 << LEVELS;

    // Each level gets its own array so the tree stays a clean feed-forward cone.
    for (genvar l = 0; l <= LEVELS; l++) begin : lvl
        localparam int W = LEAVES >> l;
        logic [PW-1:0] sum [W];

        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < W; j++) begin : g_bit
                if (j < N) begin : g_used
                    assign sum[j] = {{(PW-1){1'b0}}, data[j]};
                end else begin : g_pad
                    assign sum[j] = '0;
                end
            end
        end else begin : g_add
            for (genvar j = 0; j < W; j++) begin : g_node
                assign sum[j] = lvl[l-1].sum[2*j] + lvl[l-1].sum[2*j+1];
            end
        end
    end

    assign pop = lvl[LEVELS].sum[0];

endmodule

// File: rtl/maj_vote_pipe.sv
// Two-stage N-input vote/reduce unit with valid/ready handshake on both sides.
// S1 holds the raw beat, S2 holds popcount, result and tie flag.
module maj_vote_pipe
    import maj_vote_pkg::*;
#(
    parameter int N_IN  = 7,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN-1:0]         in_data,
    input  logic [1:0]              in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_bit,
    output logic [pop_w(N_IN)-1:0]  out_pop,
    output logic                    out_tie,
    output logic [CNT_W-1:0]        out_cnt
);

    localparam int PW = pop_w(N_IN);
    localparam logic [PW:0]   N_X  = (PW+1)'(N_IN);
    localparam logic [PW-1:0] N_PW = PW'(N_IN);

    logic             s1_v;
    logic [N_IN-1:0]  s1_data;
    mode_e            s1_mode;

    logic             s2_v;
    logic             s2_bit;
    logic [PW-1:0]    s2_pop;
    logic             s2_tie;
    logic [CNT_W-1:0] cnt;

    logic             s1_load;
    logic             s2_load;
    logic [PW-1:0]    pop;
    logic [PW:0]      pop_x2;
    logic             res_bit;
    logic             res_tie;

    // S1 may refill in the same cycle it hands its beat forward.
    assign s2_load  = s1_v && (!s2_v || out_ready);
    assign in_ready = !s1_v || s2_load;
    assign s1_load  = in_valid && in_ready;

    popcnt_tree #(.N(N_IN)) u_popcnt (
        .data (s1_data),
        .pop  (pop)
    );

    assign pop_x2 = {pop, 1'b0};

    always_comb begin
        res_bit = 1'b0;
        res_tie = 1'b0;
        case (s1_mode)
            MODE_MAJ: begin
                res_bit = pop_x2 > N_X;
                res_tie = pop_x2 == N_X;
            end
            MODE_XOR: res_bit = pop[0];
            MODE_AND: res_bit = pop == N_PW;
            MODE_OR:  res_bit = |pop;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_mode <= MODE_MAJ;
        end else begin
            if (s1_load) begin
                s1_v    <= 1'b1;
                s1_data <= in_data;
                s1_mode <= mode_e'(in_mode);
            end else if (s2_load) begin
                s1_v    <= 1'b0;
            end
        end
    end

    // S2 data only changes on a load, so it holds steady under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v   <= 1'b0;
            s2_bit <= 1'b0;
            s2_pop <= '0;
            s2_tie <= 1'b0;
            cnt    <= '0;
        end else begin
            if (s2_load) begin
                s2_v   <= 1'b1;
                s2_bit <= res_bit;
                s2_pop <= pop;
                s2_tie <= res_tie;
            end else if (out_ready) begin
                s2_v   <= 1'b0;
            end
            if (s2_v && out_ready) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = s2_v;
    assign out_bit   = s2_bit;
    assign out_pop   = s2_pop;
    assign out_tie   = s2_tie;
    assign out_cnt   = cnt;

endmodule

// File: tb/tb_maj_vote_pipe.sv
// Scoreboard bench for maj_vote_pipe: a 7-input instance (16-bit counter) and
// an 8-input instance (4-bit counter, so wrap is reached quickly).
module tb_maj_vote_pipe;
    import maj_vote_pkg::*;

    typedef struct packed {
        logic       bit_v;
        logic [6:0] pop;
        logic       tie;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
    logic [6:0] a_in_data = '0;
    logic [1:0] a_in_mode = '0;
    logic       a_out_bit, a_out_tie;
    logic [2:0] a_out_pop;
    logic [15:0] a_out_cnt;

    logic       b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
    logic [7:0] b_in_data = '0;
    logic [1:0] b_in_mode = '0;
    logic       b_out_bit, b_out_tie;
    logic [3:0] b_out_pop;
    logic [3:0] b_out_cnt;

    exp_t a_q[$];
    exp_t b_q[$];
    int   a_xfers = 0;
    int   b_xfers = 0;
    int   b_accepted = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    maj_vote_pipe #(.N_IN(7), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_bit(a_out_bit),
        .out_pop(a_out_pop), .out_tie(a_out_tie), .out_cnt(a_out_cnt)
    );

    maj_vote_pipe #(.N_IN(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bit(b_out_bit),
        .out_pop(b_out_pop), .out_tie(b_out_tie), .out_cnt(b_out_cnt)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic b, input int p, input logic t);
        exp_t e;
        e.bit_v = b;
        e.pop   = 7'(p);
        e.tie   = t;
        return e;
    endfunction

    // Straight-line reference: count ones, then apply the mode rule.
    function automatic exp_t model(input logic [7:0] d, input logic [1:0] m, input int n);
        int p = 0;
        logic b;
        for (int i = 0; i < n; i++) p += int'(d[i]);
        case (m)
            2'd0:    b = (p * 2 > n);
            2'd1:    b = p[0];
            2'd2:    b = (p == n);
            default: b = (p != 0);
        endcase
        return mk(b, p, (m == 2'd0) && (p * 2 == n));
    endfunction

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n && a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL a_spurious: got unexpected result, expected none");
            end else begin
                e = a_q.pop_front();
                check_output("a_bit", 32'(a_out_bit), 32'(e.bit_v));
                check_output("a_pop", 32'(a_out_pop), 32'(e.pop));
                check_output("a_tie", 32'(a_out_tie), 32'(e.tie));
            end
            check_output("a_cnt", 32'(a_out_cnt), 32'(a_xfers[15:0]));
            a_xfers++;
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n && b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL b_spurious: got unexpected result, expected none");
            end else begin
                e = b_q.pop_front();
                check_output("b_bit", 32'(b_out_bit), 32'(e.bit_v));
                check_output("b_pop", 32'(b_out_pop), 32'(e.pop));
                check_output("b_tie", 32'(b_out_tie), 32'(e.tie));
            end
            check_output("b_cnt", 32'(b_out_cnt), 32'(b_xfers[3:0]));
            b_xfers++;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic apply_stimulus(input bit sel_b, input logic [7:0] data,
                                  input logic [1:0] mode, input exp_t e);
        bit done = 1'b0;
        if (sel_b) begin
            b_in_valid = 1'b1; b_in_data = data; b_in_mode = mode;
        end else begin
            a_in_valid = 1'b1; a_in_data = data[6:0]; a_in_mode = mode;
        end
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = sel_b ? b_in_ready : a_in_ready;
            @(posedge clk);
            #1;
        end
        if (done) begin
            if (sel_b) begin
                b_q.push_back(e);
                b_accepted++;
            end else begin
                a_q.push_back(e);
            end
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no in_ready in 100 cycles, expected acceptance");
        end
        if (sel_b) b_in_valid = 1'b0;
        else       a_in_valid = 1'b0;
    endtask

    // Drives one beat into an empty pipe and checks it shows up two edges later.
    task automatic latency_beat(input bit sel_b, input logic [7:0] data,
                                input logic [1:0] mode, input exp_t e);
        if (sel_b) begin
            b_in_valid = 1'b1; b_in_data = data; b_in_mode = mode;
        end else begin
            a_in_valid = 1'b1; a_in_data = data[6:0]; a_in_mode = mode;
        end
        @(negedge clk);
        check_output("lat_ready", 32'(sel_b ? b_in_ready : a_in_ready), 32'd1);
        check_output("lat_valid_c0", 32'(sel_b ? b_out_valid : a_out_valid), 32'd0);
        @(posedge clk);
        #1;
        if (sel_b) begin b_q.push_back(e); b_in_valid = 1'b0; end
        else       begin a_q.push_back(e); a_in_valid = 1'b0; end
        @(negedge clk);
        check_output("lat_valid_c1", 32'(sel_b ? b_out_valid : a_out_valid), 32'd0);
        @(negedge clk);
        check_output("lat_valid_c2", 32'(sel_b ? b_out_valid : a_out_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = (a_q.size() == 0) && (b_q.size() == 0) && !a_out_valid && !b_out_valid;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d/%0d pending, expected 0/0", a_q.size(), b_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200000, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        logic [7:0] d;
        int start_x;
        int low_cycles;
        bit acc;

        #3;
        check_output("rst_b_in_ready", 32'(b_in_ready), 32'd1);
        check_output("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        check_output("rst_b_out_bit", 32'(b_out_bit), 32'd0);
        check_output("rst_b_out_pop", 32'(b_out_pop), 32'd0);
        check_output("rst_b_out_tie", 32'(b_out_tie), 32'd0);
        check_output("rst_b_out_cnt", 32'(b_out_cnt), 32'd0);
        check_output("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        check_output("rst_a_in_ready", 32'(a_in_ready), 32'd1);
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic MAJ vote, 7 inputs");
        latency_beat(1'b0, 8'b0101_0110, MODE_MAJ, mk(1'b1, 4, 1'b0));
        @(negedge clk);
        check_output("basic_out_cnt", 32'(a_out_cnt), 32'd1);
        @(posedge clk);
        #1;
        apply_stimulus(1'b0, 8'b000_0111, MODE_MAJ, mk(1'b0, 3, 1'b0));
        apply_stimulus(1'b0, 8'b000_1111, MODE_MAJ, mk(1'b1, 4, 1'b0));
        apply_stimulus(1'b0, 8'b111_1111, MODE_AND, mk(1'b1, 7, 1'b0));
        apply_stimulus(1'b0, 8'b111_1110, MODE_AND, mk(1'b0, 6, 1'b0));
        apply_stimulus(1'b0, 8'b000_0000, MODE_OR,  mk(1'b0, 0, 1'b0));
        apply_stimulus(1'b0, 8'b000_0001, MODE_XOR, mk(1'b1, 1, 1'b0));
        wait_drain();

        $display("[TB] backpressure, 10 beats");
        b_out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    d = 8'(i * 29 + 3);
                    apply_stimulus(1'b1, d, 2'(i), model(d, 2'(i), 8));
                end
            end
            begin
                repeat (5) @(negedge clk);
                check_output("bp_in_ready_low", 32'(b_in_ready), 32'd0);
                check_output("bp_accepted", 32'(b_accepted), 32'd2);
                check_output("bp_out_valid", 32'(b_out_valid), 32'd1);
                @(posedge clk);
                #1;
                b_out_ready = 1'b1;
            end
        join
        wait_drain();
        check_output("bp_out_cnt", 32'(b_out_cnt), 32'd10);

        $display("[TB] mode sweep, 8 inputs");
        apply_stimulus(1'b1, 8'hF0, MODE_MAJ, mk(1'b0, 4, 1'b1));
        apply_stimulus(1'b1, 8'hF0, MODE_XOR, mk(1'b0, 4, 1'b0));
        apply_stimulus(1'b1, 8'hF0, MODE_AND, mk(1'b0, 4, 1'b0));
        apply_stimulus(1'b1, 8'hF0, MODE_OR,  mk(1'b1, 4, 1'b0));
        apply_stimulus(1'b1, 8'hFF, MODE_AND, mk(1'b1, 8, 1'b0));
        apply_stimulus(1'b1, 8'h1F, MODE_MAJ, mk(1'b1, 5, 1'b0));
        apply_stimulus(1'b1, 8'h00, MODE_OR,  mk(1'b0, 0, 1'b0));
        apply_stimulus(1'b1, 8'h07, MODE_XOR, mk(1'b1, 3, 1'b0));
        wait_drain();

        $display("[TB] throughput, 100 cycles");
        start_x = b_xfers;
        low_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            d = 8'((i * 37) ^ (i >> 1));
            b_in_valid = 1'b1;
            b_in_data = d;
            b_in_mode = 2'(i);
            @(negedge clk);
            acc = b_in_ready;
            if (!acc) low_cycles++;
            @(posedge clk);
            #1;
            if (acc) b_q.push_back(model(d, 2'(i), 8));
        end
        b_in_valid = 1'b0;
        check_output("tp_results", 32'(b_xfers - start_x), 32'd98);
        check_output("tp_in_ready_low", 32'(low_cycles), 32'd0);
        wait_drain();

        $display("[TB] reset with both stages full");
        b_out_ready = 1'b0;
        apply_stimulus(1'b1, 8'h3C, MODE_MAJ, model(8'h3C, 2'd0, 8));
        apply_stimulus(1'b1, 8'hC3, MODE_OR,  model(8'hC3, 2'd3, 8));
        #1 rst_n = 1'b0;
        #1;
        check_output("mrst_out_valid", 32'(b_out_valid), 32'd0);
        check_output("mrst_out_cnt", 32'(b_out_cnt), 32'd0);
        check_output("mrst_in_ready", 32'(b_in_ready), 32'd1);
        a_q.delete();
        b_q.delete();
        a_xfers = 0;
        b_xfers = 0;
        b_out_ready = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        latency_beat(1'b1, 8'b1110_0001, MODE_MAJ, mk(1'b0, 4, 1'b1));

        $display("[TB] counter wrap, 17 transfers");
        for (int i = 0; i < 16; i++) begin
            d = 8'(i * 53 + 1);
            apply_stimulus(1'b1, d, 2'(i + 1), model(d, 2'(i + 1), 8));
        end
        wait_drain();
        check_output("wrap_out_cnt", 32'(b_out_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
